// File: rtl/pll_drp_sequencer.sv
// rtl/pll_drp_sequencer.sv - DRP read-modify-write sequencer for the sysclk/mcolorclk PLL
//
// On an accepted start strobe the PLL is held in reset while every entry of the
// selected profile table is applied to the PLL over its DRP port as a
// read-modify-write. Reset is then released and LOCKED is awaited before the
// one-cycle completion pulse.
//
// Ports:
//   clk       PLL input clock
//   rst_n     asynchronous active-low reset
//   sstep     one-cycle start strobe (ignored while busy)
//   state     profile select, sampled with an accepted sstep
//   srdy      one-cycle pulse when the sequence ends (success or error)
//   busy      high from accepted sstep through the srdy cycle
//   error     sticky failure flag, cleared by the next accepted sstep
//   rom_addr  {profile, index} into the synchronous profile ROM
//   rom_data  {daddr[4:0], mask[15:0], value[15:0]}, one cycle after rom_addr
//   daddr/di/dout/den/dwe/drdy  DRP port of the PLL
//   locked    PLL LOCKED
//   pll_rst   PLL RST
module pll_drp_sequencer #(
  parameter int NUM_REGS     = 23,
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sstep,
  input  logic [2:0]  state,
  output logic        srdy,
  output logic        busy,
  output logic        error,
  output logic [7:0]  rom_addr,
  input  logic [36:0] rom_data,
  output logic [4:0]  daddr,
  output logic [15:0] di,
  input  logic [15:0] dout,
  output logic        den,
  output logic        dwe,
  input  logic        drdy,
  input  logic        locked,
  output logic        pll_rst
);

  localparam int WD_W = $clog2(DRDY_TIMEOUT + 1);
  localparam int LK_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [4:0]      LAST_IDX = 5'(NUM_REGS - 1);
  localparam logic [WD_W-1:0] WD_MAX   = WD_W'(DRDY_TIMEOUT);
  localparam logic [LK_W-1:0] LK_MAX   = LK_W'(LOCK_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ROM_WAIT,
    S_READ,
    S_WAIT_RRDY,
    S_WRITE,
    S_WAIT_WRDY,
    S_RELEASE,
    S_WAIT_LOCK,
    S_DONE
  } fsm_t;

  fsm_t fsm_q, fsm_d;

  logic [2:0]      profile_q;
  logic [4:0]      index_q;
  logic [4:0]      daddr_q;
  logic [15:0]     mask_q;
  logic [15:0]     value_q;
  logic [15:0]     di_q;
  logic [WD_W-1:0] wd_q;
  logic [LK_W-1:0] lock_q;
  logic            error_q;

  logic accept;
  logic entry_cap;
  logic di_cap;
  logic idx_inc;
  logic set_err;
  logic den_c;
  logic dwe_c;
  logic srdy_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= S_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    accept    = 1'b0;
    entry_cap = 1'b0;
    di_cap    = 1'b0;
    idx_inc   = 1'b0;
    set_err   = 1'b0;
    den_c     = 1'b0;
    dwe_c     = 1'b0;
    srdy_c    = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (sstep) begin
          accept = 1'b1;
          fsm_d  = S_ROM_WAIT;
        end
      end
      S_ROM_WAIT: begin
        fsm_d = S_READ;
      end
      S_READ: begin
        den_c     = 1'b1;
        entry_cap = 1'b1;
        fsm_d     = S_WAIT_RRDY;
      end
      S_WAIT_RRDY: begin
        // drdy wins over a watchdog expiring in the same cycle
        if (drdy) begin
          di_cap = 1'b1;
          fsm_d  = S_WRITE;
        end else if (wd_q == WD_MAX) begin
          set_err = 1'b1;
          fsm_d   = S_RELEASE;
        end
      end
      S_WRITE: begin
        den_c = 1'b1;
        dwe_c = 1'b1;
        fsm_d = S_WAIT_WRDY;
      end
      S_WAIT_WRDY: begin
        if (drdy) begin
          if (index_q == LAST_IDX) begin
            fsm_d = S_RELEASE;
          end else begin
            idx_inc = 1'b1;
            fsm_d   = S_ROM_WAIT;
          end
        end else if (wd_q == WD_MAX) begin
          set_err = 1'b1;
          fsm_d   = S_RELEASE;
        end
      end
      S_RELEASE: begin
        fsm_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked) begin
          fsm_d = S_DONE;
        end else if (lock_q == LK_MAX) begin
          set_err = 1'b1;
          fsm_d   = S_DONE;
        end
      end
      S_DONE: begin
        srdy_c = 1'b1;
        fsm_d  = S_IDLE;
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  // Profile and table index; rom_addr changes on entry to ROM_WAIT so the
  // synchronous ROM output is valid during READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      profile_q <= 3'd0;
      index_q   <= 5'd0;
    end else if (accept) begin
      profile_q <= state;
      index_q   <= 5'd0;
    end else if (idx_inc) begin
      index_q <= index_q + 5'd1;
    end
  end

  // Table entry is captured while READ is driving daddr straight from the ROM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      daddr_q <= 5'd0;
      mask_q  <= 16'd0;
      value_q <= 16'd0;
    end else if (entry_cap) begin
      daddr_q <= rom_data[36:32];
      mask_q  <= rom_data[31:16];
      value_q <= rom_data[15:0];
    end
  end

  // Mask bit set keeps the PLL's current bit; clear takes the table value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      di_q <= 16'd0;
    end else if (di_cap) begin
      di_q <= (dout & mask_q) | (value_q & ~mask_q);
    end
  end

  // DRDY watchdog: holds the number of cycles since the last den pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if (den_c) begin
      wd_q <= WD_W'(1);
    end else if ((fsm_q == S_WAIT_RRDY || fsm_q == S_WAIT_WRDY) && wd_q != WD_MAX) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

  // Lock wait counter: 0 on the first WAIT_LOCK cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= '0;
    end else if (fsm_q == S_RELEASE) begin
      lock_q <= '0;
    end else if (fsm_q == S_WAIT_LOCK && lock_q != LK_MAX) begin
      lock_q <= lock_q + LK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else if (accept) begin
      error_q <= 1'b0;
    end else if (set_err) begin
      error_q <= 1'b1;
    end
  end

  assign rom_addr = {profile_q, index_q};
  assign daddr    = (fsm_q == S_READ) ? rom_data[36:32] : daddr_q;
  assign di       = di_q;
  assign den      = den_c;
  assign dwe      = dwe_c;
  assign srdy     = srdy_c;
  assign busy     = (fsm_q != S_IDLE);
  assign error    = error_q;
  // PLL is held in reset only while table entries are being applied.
  assign pll_rst  = (fsm_q == S_ROM_WAIT) || (fsm_q == S_READ) ||
                    (fsm_q == S_WAIT_RRDY) || (fsm_q == S_WRITE) ||
                    (fsm_q == S_WAIT_WRDY);

endmodule
